// File: rtl/sram_frame_arbiter_if.sv
// Client-side bundle of the shared-SRAM arbiter: requests, handshakes, per-client strobes and
// the grant/read-data returns. Clients use the master modport; the arbiter uses slave.
interface sram_frame_arbiter_if #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 16
);
  localparam int unsigned OwnerW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [NUM_CLIENTS-1:0]        req;
  logic [NUM_CLIENTS-1:0]        step_done;
  logic [NUM_CLIENTS-1:0]        client_oe_n;
  logic [NUM_CLIENTS-1:0]        client_we_n;
  logic [NUM_CLIENTS*ADDR_W-1:0] client_addr;
  logic [NUM_CLIENTS*DATA_W-1:0] client_wdata;
  logic [NUM_CLIENTS-1:0]        grant;
  logic [OwnerW-1:0]             owner_id;
  logic [DATA_W-1:0]             rdata;
  logic                          timeout;

  modport master (
    output req, step_done, client_oe_n, client_we_n, client_addr, client_wdata,
    input  grant, owner_id, rdata, timeout
  );

  modport slave (
    input  req, step_done, client_oe_n, client_we_n, client_addr, client_wdata,
    output grant, owner_id, rdata, timeout
  );
endinterface

// File: rtl/sram_frame_arbiter.sv
// Round-robin time-slice arbiter for one asynchronous frame-buffer SRAM shared by NUM_CLIENTS.
// Define SLICE_TIMEOUT_EN to force release of a slice after MAX_SLICE grant cycles.
module sram_frame_arbiter #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_SLICE   = 1024
) (
  input  logic                Clk,
  input  logic                Reset_N,
  sram_frame_arbiter_if.slave bus,
  inout  wire  [DATA_W-1:0]   SRAM_DQ,
  output logic [ADDR_W-1:0]   SRAM_ADDRESS,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N
);
  localparam int unsigned OwnerW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int unsigned IdxW   = OwnerW + 1;
  localparam logic [OwnerW-1:0] LastId = OwnerW'(NUM_CLIENTS - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e            state_q, state_d;
  logic [OwnerW-1:0] owner_q, owner_d;
  logic [OwnerW-1:0] ptr_q, ptr_d;
  logic [OwnerW-1:0] pick_id;
  logic [IdxW-1:0]   wrap_idx;
  logic              pick_valid;
  logic              granted;
  logic              owner_done;
  logic              expire;
  logic [NUM_CLIENTS-1:0] grant_vec;

  logic              oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0] addr_arr  [NUM_CLIENTS];
  logic [DATA_W-1:0] wdata_arr [NUM_CLIENTS];

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign addr_arr[g]  = bus.client_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus.client_wdata[g*DATA_W +: DATA_W];
  end

  assign granted    = (state_q == StGrant);
  assign owner_done = bus.step_done[owner_q];

  // First requester at or after the round-robin pointer, wrapping modulo NUM_CLIENTS.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    wrap_idx   = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      wrap_idx = {1'b0, ptr_q} + IdxW'(k);
      if (wrap_idx >= IdxW'(NUM_CLIENTS)) wrap_idx = wrap_idx - IdxW'(NUM_CLIENTS);
      if (!pick_valid && bus.req[wrap_idx[OwnerW-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = wrap_idx[OwnerW-1:0];
      end
    end
  end

`ifdef SLICE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MAX_SLICE + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  assign expire = granted && (cnt_q == CntW'(MAX_SLICE - 1));

  always_comb begin
    cnt_d     = granted ? cnt_q + CntW'(1) : '0;
    timeout_d = timeout_q | (expire & ~owner_done);
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle, StTurn: begin
        if (pick_valid) begin
          state_d = StGrant;
          owner_d = pick_id;
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        if (owner_done || expire) begin
          state_d = StTurn;
          ptr_d   = (owner_q == LastId) ? '0 : owner_q + OwnerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Collision resolves in favour of the write so DQ is never driven from both ends.
  always_comb begin
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    addr_d  = '0;
    wdata_d = '0;
    if (granted) begin
      we_n_d  = bus.client_we_n[owner_q];
      oe_n_d  = bus.client_oe_n[owner_q] | ~bus.client_we_n[owner_q];
      addr_d  = addr_arr[owner_q];
      wdata_d = wdata_arr[owner_q];
    end
    rdata_d = oe_n_q ? rdata_q : SRAM_DQ;
  end

  always_comb begin
    grant_vec = '0;
    if (granted) grant_vec[owner_q] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign SRAM_DQ      = we_n_q ? {DATA_W{1'bz}} : wdata_q;
  assign SRAM_ADDRESS = addr_q;
  assign SRAM_OE_N    = oe_n_q;
  assign SRAM_WE_N    = we_n_q;
  assign SRAM_CE_N    = 1'b0;
  assign SRAM_UB_N    = 1'b0;
  assign SRAM_LB_N    = 1'b0;

  assign bus.grant    = grant_vec;
  assign bus.owner_id = owner_q;
  assign bus.rdata    = rdata_q;

endmodule

// File: doc/sram_frame_arbiter.md
Name: sram_frame_arbiter

Overview:
- Parametrised successor to the two-controller SRAM time-slice switch in the graphics accelerator.
- Arbitrates one shared asynchronous 16-bit frame-buffer SRAM among NUM_CLIENTS controllers (next-frame drawer, current-frame VGA reader, future blitters) with round-robin grants and a step_done handshake.
- Drives SRAM control from registers, owns the DQ tristate, returns registered read data, and inserts a bus-turnaround cycle between owners.

Parameters:
- NUM_CLIENTS, 2, number of requesting controllers (2..8).
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- MAX_SLICE, 1024, grant-length limit in cycles; used only with SLICE_TIMEOUT_EN.

Ports:
- Clk  in  1  system clock.
- Reset_N  in  1  asynchronous active-low reset.
- req  in  NUM_CLIENTS  per-client access request.
- step_done  in  NUM_CLIENTS  per-client "slice finished, release bus".
- client_oe_n  in  NUM_CLIENTS  per-client read strobe, active low.
- client_we_n  in  NUM_CLIENTS  per-client write strobe, active low.
- client_addr  in  NUM_CLIENTS*ADDR_W  flattened addresses; client i at bits [i*ADDR_W +: ADDR_W].
- client_wdata  in  NUM_CLIENTS*DATA_W  flattened write data, same packing.
- grant  out  NUM_CLIENTS  one-hot or zero ownership.
- owner_id  out  $clog2(NUM_CLIENTS) (min 1)  index of current or last owner.
- rdata  out  DATA_W  registered SRAM read data, broadcast to all clients.
- timeout  out  1  sticky slice-timeout flag.
- SRAM_DQ  inout  DATA_W  SRAM data bus.
- SRAM_ADDRESS  out  ADDR_W  registered address.
- SRAM_OE_N  out  1  registered output enable.
- SRAM_WE_N  out  1  registered write enable.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  tied 0.

Behaviour:
- Reset (async, takes effect immediately, including mid-slice):
  - grant=0, owner_id=0, rr pointer=0, state=IDLE.
  - SRAM_OE_N=1, SRAM_WE_N=1, SRAM_ADDRESS=0, rdata=0, timeout=0, DQ high-Z.
- States:
  - IDLE: grant=0. If any req, select the first requester at or after the rr pointer (wrapping modulo NUM_CLIENTS), load owner_id, go to GRANT. grant[owner] is high the next cycle.
  - GRANT: grant[owner]=1. req may drop; grant is held until step_done[owner]. On step_done[owner] go to TURN; grant falls the next cycle; pointer=(owner+1) mod NUM_CLIENTS.
  - TURN: one cycle, grant=0, bus released. If any req, arbitrate as in IDLE and go to GRANT; else go to IDLE.
- step_done from a non-owner is ignored, in every state.
- Mux and strobes:
  - While grant[i]=1, the mux selects client i's oe_n/we_n/addr/wdata. Otherwise it selects the inactive set: oe_n=1, we_n=1, addr=0, wdata=0.
  - The selected values are registered into SRAM_OE_N/SRAM_WE_N/SRAM_ADDRESS and a wdata register, giving 1-cycle latency.
  - Collision: if the selected we_n=0 and oe_n=0, the write wins and the registered OE_N is forced to 1.
- DQ drive and read capture:
  - DQ is driven with the wdata register only while the registered SRAM_WE_N=0; otherwise high-Z.
  - rdata <= SRAM_DQ on each cycle where the registered SRAM_OE_N=0; otherwise rdata holds. Client sees read data 2 cycles after presenting oe_n=0 with its address.
- Guaranteed idle cycle: after step_done, the registered strobes are inactive for at least one cycle before a new owner's strobes appear, so there is never DQ contention between owners.
- Fairness: with all clients continuously requesting, grants rotate 0,1,…,N-1,0. Worst-case wait is (N-1) slices plus N turnaround cycles.
- owner_id holds the last owner while in IDLE.

Optional Feature:
- Macro: SLICE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches MAX_SLICE with no step_done, the arbiter behaves exactly as if step_done[owner] were asserted (go to TURN, advance pointer) and sets timeout=1.
  - timeout clears only on reset.
- Undefined: no counter; timeout tied 0; a grant lasts indefinitely until step_done.

Test Plan:
- Reset_N low mid-GRANT with client 1 writing -> same cycle: grant=0, SRAM_WE_N=1, DQ high-Z; after release, first grant goes to client 0 when both request.
- N=2, both req held, each asserts step_done 4 cycles after its grant -> grant sequence 01,10,01,10 with exactly one all-zero cycle between owners; SRAM_OE_N/SRAM_WE_N high in that cycle.
- Client 0 write: addr=0x00010, wdata=0xBEEF, we_n=0 -> next cycle SRAM_ADDRESS=0x00010, SRAM_WE_N=0, DQ=0xBEEF. Then read with the SRAM model returning 0xBEEF -> rdata=0xBEEF 2 cycles after oe_n=0.
- N=4, req=4'b1010 with pointer=2 -> grant[3] first, then grant[1]. A non-owner step_done pulse during a grant changes nothing.
- Client drives oe_n=0 and we_n=0 together -> SRAM_WE_N=0 and SRAM_OE_N=1.
- SLICE_TIMEOUT_EN defined, MAX_SLICE=8, owner never asserts step_done -> grant drops after 8 GRANT cycles, timeout=1 and stays 1, next requester is granted after TURN.
